// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU controller: opcodes (also used as ALU op selects),
// register-file write-source codes and the sequencer state encoding.
package cpu_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_NAND  = 4'h3;
  localparam logic [3:0] OP_SHL   = 4'h4;
  localparam logic [3:0] OP_SHR   = 4'h5;
  localparam logic [3:0] OP_OUT   = 4'h6;
  localparam logic [3:0] OP_IN    = 4'h7;
  localparam logic [3:0] OP_MOV   = 4'h8;
  localparam logic [3:0] OP_LOADI = 4'h9;
  localparam logic [3:0] OP_BRZ   = 4'hA;
  localparam logic [3:0] OP_BRN   = 4'hB;
  localparam logic [3:0] OP_JMP   = 4'hC;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [1:0] WSRC_ALU = 2'd0;
  localparam logic [1:0] WSRC_IMM = 2'd1;
  localparam logic [1:0] WSRC_IN  = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_IMM_WAIT,
    S_IMM,
    S_IO_WAIT,
    S_HALT
  } state_t;

  function automatic logic is_two_byte(input logic [3:0] op);
    return op inside {OP_LOADI, OP_BRZ, OP_BRN, OP_JMP};
  endfunction

endpackage

// File: rtl/cpu_control_unit.sv
// Instruction sequencer: fetches and decodes bytes from synchronous-read memory,
// drives the ALU op select and register-file writeback, and runs the IN/OUT handshakes.
module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] imem_addr,
  input  logic [7:0]      imem_rdata,
  output logic [3:0]      alu_sel,
  input  logic [7:0]      alu_result,
  input  logic            flag_n,
  input  logic            flag_z,
  output logic [1:0]      rf_ra,
  output logic [1:0]      rf_rb,
  output logic            rf_we,
  output logic [1:0]      rf_wa,
  output logic [1:0]      rf_wsrc,
  output logic [7:0]      imm,
  input  logic [7:0]      in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [7:0]      out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            halted
);

  state_t          state, state_next;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] target;
  logic [7:0]      ir;
  logic [3:0]      opcode;
  logic [1:0]      rd;
  logic [1:0]      rs;

  // in_data goes straight to the register-file write mux; only its handshake is sequenced here.
  logic unused_in_data;
  assign unused_in_data = ^in_data;

  assign opcode    = ir[7:4];
  assign rd        = ir[3:2];
  assign rs        = ir[1:0];
  assign rf_wa     = rd;
  assign imem_addr = pc;
  assign pc_inc    = pc + PC_W'(1);
  assign target    = PC_W'(imem_rdata);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_FETCH;
      pc       <= PC_W'(RESET_PC);
      ir       <= '0;
      imm      <= '0;
      out_data <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_DECODE: begin
          ir <= imem_rdata;
          pc <= pc_inc;
        end
        S_EXEC: begin
          if (opcode == OP_OUT) out_data <= alu_result;
        end
        S_IMM: begin
          imm <= imem_rdata;
          case (opcode)
            OP_LOADI: pc <= pc_inc;
            OP_JMP:   pc <= target;
            OP_BRZ:   pc <= flag_z ? target : pc_inc;
            OP_BRN:   pc <= flag_n ? target : pc_inc;
            default:  ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    alu_sel    = OP_NOP;
    rf_ra      = '0;
    rf_rb      = '0;
    rf_we      = 1'b0;
    rf_wsrc    = WSRC_ALU;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    halted     = 1'b0;
    case (state)
      S_FETCH: state_next = S_DECODE;
      S_DECODE: begin
        // ir is not loaded yet, so decode straight from the memory byte.
        if (is_two_byte(imem_rdata[7:4]))      state_next = S_IMM_WAIT;
        else if (imem_rdata[7:4] == OP_HALT)   state_next = S_HALT;
        else                                   state_next = S_EXEC;
      end
      S_EXEC: begin
        rf_ra      = rd;
        rf_rb      = rs;
        state_next = S_FETCH;
        if (opcode <= OP_MOV) alu_sel = opcode;
        case (opcode)
          OP_ADD, OP_SUB, OP_NAND, OP_SHL, OP_SHR, OP_MOV: rf_we = 1'b1;
          OP_OUT, OP_IN: state_next = S_IO_WAIT;
          default: ;
        endcase
      end
      S_IMM_WAIT: state_next = S_IMM;
      S_IMM: begin
        state_next = S_FETCH;
        if (opcode == OP_LOADI) begin
          rf_we   = 1'b1;
          rf_wsrc = WSRC_IMM;
        end
      end
      S_IO_WAIT: begin
        if (opcode == OP_OUT) begin
          out_valid = 1'b1;
          if (out_ready) state_next = S_FETCH;
        end else begin
          in_ready = 1'b1;
          if (in_valid) begin
            rf_we      = 1'b1;
            rf_wsrc    = WSRC_IN;
            state_next = S_FETCH;
          end
        end
      end
      S_HALT: halted = 1'b1;
      default: state_next = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: models instruction memory, register file and ALU,
// and scoreboards register writes and OUT transfers against expected values.
module tb_cpu_control_unit;

  typedef struct {
    logic [1:0] wa;
    logic [7:0] data;
    int         cyc;
  } wr_t;

  logic       clk;
  logic       rst;
  logic [7:0] imem_addr;
  logic [3:0] alu_sel;
  logic [1:0] rf_ra, rf_rb, rf_wa, rf_wsrc;
  logic       rf_we;
  logic [7:0] imm;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       halted;

  logic [7:0] mem [256];
  logic [7:0] rdata_q;
  logic [7:0] rf [4];
  logic [7:0] a_d, b_d, alu_res, wdata;
  logic       fz = 1'b0;
  logic       fn = 1'b0;

  int cyc_abs = 0;
  int base = 0;
  int errors = 0;
  int checks = 0;
  wr_t        wq[$];
  logic [7:0] oq[$];

  cpu_control_unit #(.PC_W(8), .RESET_PC(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_rdata (rdata_q),
    .alu_sel    (alu_sel),
    .alu_result (alu_res),
    .flag_n     (fn),
    .flag_z     (fz),
    .rf_ra      (rf_ra),
    .rf_rb      (rf_rb),
    .rf_we      (rf_we),
    .rf_wa      (rf_wa),
    .rf_wsrc    (rf_wsrc),
    .imm        (imm),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_abs <= cyc_abs + 1;
  always @(posedge clk) rdata_q <= mem[imem_addr];

  assign a_d = rf[rf_ra];
  assign b_d = rf[rf_rb];

  always_comb begin
    case (alu_sel)
      4'd1:    alu_res = a_d + b_d;
      4'd2:    alu_res = a_d - b_d;
      4'd3:    alu_res = ~(a_d & b_d);
      4'd4:    alu_res = a_d << 1;
      4'd5:    alu_res = a_d >> 1;
      4'd6:    alu_res = a_d;
      4'd8:    alu_res = b_d;
      default: alu_res = 8'h00;
    endcase
  end

  always @(posedge clk) begin
    if (alu_sel inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8}) begin
      fz <= (alu_res == 8'h00);
      fn <= alu_res[7];
    end
  end

  assign wdata = (rf_wsrc == 2'd0) ? alu_res :
                 (rf_wsrc == 2'd1) ? rdata_q :
                 (rf_wsrc == 2'd2) ? in_data : 8'hxx;

  always @(posedge clk) if (rst && rf_we) rf[rf_wa] <= wdata;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
  endtask

  // Leaves the bench at posedge+1 of cycle 1 (first FETCH after release).
  task automatic do_reset();
    rst = 1'b0;
    repeat (2) next_cycle();
    rst = 1'b1;
    base = cyc_abs - 1;
  endtask

  task automatic sb_monitor();
    wr_t e;
    logic [7:0] od;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && rf_we === 1'b1) begin
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL rf_write_unexpected: got wa=%0d data=%h cycle=%0d, expected no write",
                   rf_wa, wdata, cyc_abs - base);
        end else begin
          e = wq.pop_front();
          if (rf_wa !== e.wa || wdata !== e.data || (cyc_abs - base) != e.cyc) begin
            errors++;
            $display("FAIL rf_write: got wa=%0d data=%h cycle=%0d, expected wa=%0d data=%h cycle=%0d",
                     rf_wa, wdata, cyc_abs - base, e.wa, e.data, e.cyc);
          end
        end
      end
      if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (oq.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected: got %h, expected no transfer", out_data);
        end else begin
          od = oq.pop_front();
          if (out_data !== od) begin
            errors++;
            $display("FAIL out_transfer: got %h, expected %h", out_data, od);
          end
        end
      end
    end
  endtask

  task automatic test_program();
    logic [3:0] exp_sel;
    fill_mem();
    mem[0] = 8'h90; mem[1] = 8'h05; mem[2] = 8'h94; mem[3] = 8'h03; mem[4] = 8'h11;
    wq.push_back('{wa: 2'd0, data: 8'h05, cyc: 4});
    wq.push_back('{wa: 2'd1, data: 8'h03, cyc: 8});
    wq.push_back('{wa: 2'd0, data: 8'h08, cyc: 11});
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k <= 12) begin
        exp_sel = (k == 11) ? 4'd1 : 4'd0;
        checks++;
        if (alu_sel !== exp_sel) begin
          errors++;
          $display("FAIL prog_alu_sel_c%0d: got %0d, expected %0d", k, alu_sel, exp_sel);
        end
      end
      next_cycle();
    end
    checks++;
    if (rf[0] !== 8'h08) begin
      errors++; $display("FAIL prog_r0: got %h, expected 08", rf[0]);
    end
    checks++;
    if (imm !== 8'h03) begin
      errors++; $display("FAIL prog_imm: got %h, expected 03", imm);
    end
    checks++;
    if (halted !== 1'b1) begin
      errors++; $display("FAIL prog_halted: got %b, expected 1", halted);
    end
    checks++;
    if (wq.size() != 0) begin
      errors++; $display("FAIL prog_pending_writes: got %0d, expected 0", wq.size());
    end
  endtask

  task automatic test_branch();
    logic [7:0] ta [4] = '{8'h07, 8'h07, 8'h02, 8'h07};
    logic [7:0] tb [4] = '{8'h07, 8'h02, 8'h07, 8'h02};
    logic [7:0] op [4] = '{8'hA0, 8'hA0, 8'hB0, 8'hB0};
    logic [7:0] tg [4] = '{8'h20, 8'h20, 8'h30, 8'h30};
    logic [7:0] ex [4] = '{8'h20, 8'h07, 8'h30, 8'h07};
    for (int c = 0; c < 4; c++) begin
      fill_mem();
      mem[0] = 8'h90; mem[1] = ta[c]; mem[2] = 8'h94; mem[3] = tb[c];
      mem[4] = 8'h21; mem[5] = op[c]; mem[6] = tg[c];
      wq.push_back('{wa: 2'd0, data: ta[c], cyc: 4});
      wq.push_back('{wa: 2'd1, data: tb[c], cyc: 8});
      wq.push_back('{wa: 2'd0, data: 8'(ta[c] - tb[c]), cyc: 11});
      do_reset();
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk);
        if (k == 16) begin
          checks++;
          if (imem_addr !== ex[c]) begin
            errors++;
            $display("FAIL branch_pc_case%0d: got %h, expected %h", c, imem_addr, ex[c]);
          end
        end
        next_cycle();
      end
      checks++;
      if (halted !== 1'b1 || wq.size() != 0) begin
        errors++;
        $display("FAIL branch_end_case%0d: got halted=%b pending=%0d, expected halted=1 pending=0",
                 c, halted, wq.size());
      end
    end
  endtask

  task automatic test_out();
    logic exp_v;
    fill_mem();
    mem[0] = 8'h98; mem[1] = 8'h5C; mem[2] = 8'h68;
    wq.push_back('{wa: 2'd2, data: 8'h5C, cyc: 4});
    oq.push_back(8'h5C);
    do_reset();
    for (int k = 1; k <= 14; k++) begin
      out_ready = (k == 13);
      @(negedge clk);
      if (k >= 5) begin
        exp_v = (k >= 8 && k <= 13);
        checks++;
        if (out_valid !== exp_v) begin
          errors++;
          $display("FAIL out_valid_c%0d: got %b, expected %b", k, out_valid, exp_v);
        end
        if (exp_v) begin
          checks++;
          if (out_data !== 8'h5C) begin
            errors++;
            $display("FAIL out_data_c%0d: got %h, expected 5c", k, out_data);
          end
        end
      end
      next_cycle();
    end
    out_ready = 1'b0;
    checks++;
    if (oq.size() != 0 || wq.size() != 0) begin
      errors++;
      $display("FAIL out_pending: got out=%0d wr=%0d, expected 0 0", oq.size(), wq.size());
    end
  endtask

  task automatic test_in();
    logic exp_r;
    fill_mem();
    mem[0] = 8'h7C;
    wq.push_back('{wa: 2'd3, data: 8'hA5, cyc: 7});
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      in_valid = (k >= 7);
      in_data  = (k >= 7) ? 8'hA5 : 8'h00;
      @(negedge clk);
      exp_r = (k >= 4 && k <= 7);
      checks++;
      if (in_ready !== exp_r) begin
        errors++;
        $display("FAIL in_ready_c%0d: got %b, expected %b", k, in_ready, exp_r);
      end
      if (k == 8) begin
        checks++;
        if (imem_addr !== 8'h01) begin
          errors++;
          $display("FAIL in_next_fetch: got %h, expected 01", imem_addr);
        end
      end
      next_cycle();
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
    checks++;
    if (rf[3] !== 8'hA5 || wq.size() != 0) begin
      errors++;
      $display("FAIL in_result: got r3=%h pending=%0d, expected a5 0", rf[3], wq.size());
    end
  endtask

  task automatic test_reset();
    fill_mem();
    mem[0] = 8'h9C; mem[1] = 8'hE7; mem[2] = 8'h11;
    wq.push_back('{wa: 2'd3, data: 8'hE7, cyc: 4});
    do_reset();
    repeat (6) next_cycle();
    checks++;
    if (alu_sel !== 4'd1 || rf_we !== 1'b1 || imm !== 8'hE7 || imem_addr !== 8'h03) begin
      errors++;
      $display("FAIL reset_pre_exec: got sel=%0d we=%b imm=%h pc=%h, expected 1 1 e7 03",
               alu_sel, rf_we, imm, imem_addr);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (imem_addr !== 8'h00 || alu_sel !== 4'd0 || rf_we !== 1'b0 || imm !== 8'h00) begin
      errors++;
      $display("FAIL reset_async: got pc=%h sel=%0d we=%b imm=%h, expected 00 0 0 00",
               imem_addr, alu_sel, rf_we, imm);
    end
    checks++;
    if (halted !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== 8'h00 ||
        rf_wsrc !== 2'd0 || rf_ra !== 2'd0 || rf_rb !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: got h=%b ov=%b ir=%b od=%h ws=%0d ra=%0d rb=%0d, expected all 0",
               halted, out_valid, in_ready, out_data, rf_wsrc, rf_ra, rf_rb);
    end
    checks++;
    if (wq.size() != 0) begin
      errors++; $display("FAIL reset_pending: got %0d, expected 0", wq.size());
    end
  endtask

  task automatic test_wrap_halt();
    logic [7:0] exp_a;
    fill_mem();
    mem[0] = 8'hC0; mem[1] = 8'hFE; mem[8'hFE] = 8'hC0; mem[8'hFF] = 8'h00;
    do_reset();
    for (int k = 1; k <= 30; k++) begin
      if (k == 5) mem[0] = 8'hF0;
      @(negedge clk);
      if (k == 7 || k == 9) begin
        exp_a = (k == 7) ? 8'hFF : 8'h00;
        checks++;
        if (imem_addr !== exp_a) begin
          errors++;
          $display("FAIL wrap_pc_c%0d: got %h, expected %h", k, imem_addr, exp_a);
        end
      end
      checks++;
      if (halted !== (k >= 11)) begin
        errors++;
        $display("FAIL halted_c%0d: got %b, expected %b", k, halted, (k >= 11));
      end
      if (k >= 11) begin
        checks++;
        if (imem_addr !== 8'h01 || rf_we !== 1'b0 || alu_sel !== 4'd0) begin
          errors++;
          $display("FAIL halt_frozen_c%0d: got pc=%h we=%b sel=%0d, expected 01 0 0",
                   k, imem_addr, rf_we, alu_sel);
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    rst       = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    fork
      sb_monitor();
    join_none
    test_program();
    test_branch();
    test_out();
    test_in();
    test_reset();
    test_wrap_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_control_unit.md
Name: cpu_control_unit

Overview:
Instruction sequencer that drives the 8-bit ALU's 4-bit op select and consumes its N/Z flags. It fetches bytes from a synchronous-read instruction memory, decodes them, and controls register-file writeback. It also runs the valid/ready handshakes for the IN/OUT ports. It sits between instruction memory, the register file, the ALU and the I/O pins.

Parameters:
PC_W, 8, program counter / instruction address width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; asynchronous, active-low
imem_addr  out  PC_W  instruction address (registered, equals pc)
imem_rdata  in  8  instruction byte; valid 1 cycle after imem_addr changes
alu_sel  out  4  ALU op select: 0 NOP, 1 ADD, 2 SUB, 3 NAND, 4 SHL, 5 SHR, 6 OUT, 7 IN, 8 MOV
alu_result  in  8  ALU result
flag_n, flag_z  in  1  ALU flags (registered in ALU)
rf_ra, rf_rb  out  2  register-file read addresses (rd, rs) -> ALU in_A, in_B
rf_we  out  1  register-file write enable
rf_wa  out  2  write address (always rd)
rf_wsrc  out  2  write source: 0 alu_result, 1 imm, 2 in_data
imm  out  8  latched immediate byte
in_data  in  8  input port data
in_valid  in  1  input data valid
in_ready  out  1  controller accepts in_data
out_data  out  8  output port data
out_valid  out  1  output data valid
out_ready  in  1  sink accepts out_data
halted  out  1  high in HALT state

Behaviour:
- Instruction byte: [7:4] opcode, [3:2] rd, [1:0] rs. Opcodes 0-8 are ALU ops. 9 LOADI, A BRZ, B BRN and C JMP are two-byte: the second byte is imm or target. F is HALT. D and E execute as NOP.
- Reset (rst=0, async): state=FETCH, pc=RESET_PC, ir=0, imm=0. alu_sel, rf_we, rf_wsrc, rf_ra, rf_rb, in_ready, out_valid, out_data and halted all go to 0. Any in-flight handshake is abandoned.
- States: FETCH, DECODE, EXEC, IMM_WAIT, IMM, IO_WAIT, HALT.
- FETCH: wait for memory latency, then go to DECODE.
- DECODE: ir<=imem_rdata, pc<=pc+1. Two-byte opcode -> IMM_WAIT. F -> HALT. Otherwise -> EXEC.
- EXEC: alu_sel=opcode, rf_ra=rd, rf_rb=rs.
  - Ops 1-5 and 8: rf_we=1, rf_wsrc=0, then FETCH. Total 3 cycles per instruction.
  - OUT (6): out_data<=alu_result, then IO_WAIT.
  - IN (7): go to IO_WAIT.
  - NOP / D / E: go to FETCH with no write.
- alu_sel=0 (NOP) in every state except EXEC, so the ALU result and flags hold.
- IMM_WAIT: one-cycle wait, then IMM.
- IMM: imm<=imem_rdata, then FETCH. Total 4 cycles.
  - LOADI: rf_we=1, rf_wsrc=1, write data = imem_rdata, pc<=pc+1.
  - JMP: pc<=imem_rdata.
  - BRZ: pc<=imem_rdata if flag_z=1, else pc+1.
  - BRN: pc<=imem_rdata if flag_n=1, else pc+1.
  - Flags are sampled in IMM and reflect the last ALU op.
- IO_WAIT, OUT: out_valid=1 with out_data stable until the cycle where out_valid&&out_ready, then FETCH. out_valid deasserts the next cycle.
- IO_WAIT, IN: in_ready=1. On in_valid&&in_ready, rf_we=1, rf_wsrc=2, write in_data to rd, then FETCH.
- A handshake completing in the first IO_WAIT cycle is legal (1-cycle wait). Waiting is unbounded.
- HALT: terminal until reset. halted=1, no memory or register-file activity, pc frozen.
- pc wraps modulo 2^PC_W (0xFF+1 -> 0x00). A two-byte instruction at the last address reads its operand from address 0.
- Only one register-file write per instruction. Branch and jump never write the register file.

Decomposition:
- Shared package cpu_pkg: opcode localparams (OP_NOP..OP_MOV, OP_LOADI, OP_BRZ, OP_BRN, OP_JMP, OP_HALT), state encoding, and rf_wsrc encodings (WSRC_ALU, WSRC_IMM, WSRC_IN).
- The ALU reuses the opcode localparams for alu_sel.
- Single module; no sub-module needed.

Test Plan:
- Reset mid-EXEC of ADD (rst low for 1 cycle) -> pc=RESET_PC, state FETCH, rf_we=0, alu_sel=0 immediately (asynchronous).
- Program 0x90,0x05,0x94,0x03,0x11 (LOADI r0,5; LOADI r1,3; ADD r0,r1), with the ALU and register file modelled in the bench -> r0=8. Writes occur at cycles 4, 8 and 11 after reset release; alu_sel=1 only in cycle 11.
- SUB producing 0, then BRZ 0x20 -> pc=0x20. Repeat with a nonzero result -> pc=address after the operand.
- OUT with out_ready held low 5 cycles -> out_valid high and out_data stable for 6 cycles, drops the cycle after acceptance.
- IN with in_valid arriving 3 cycles late, value 0xA5 -> rd=0xA5, in_ready high until acceptance, then FETCH.
- JMP 0x00 placed at 0xFE/0xFF, and HALT at 0x00 -> pc wraps; halted=1 and stays 1 for 20 cycles with imem_addr frozen.
